// File: rtl/clk_div_switch.sv
// clk_div_switch
//   Glitch-free programmable clock divider. Produces a 50%-duty clock at
//   clk / (2*(half+1)). The half-period can be changed at runtime through a
//   valid/ready handshake. New ratios and stop requests only take effect at
//   phase boundaries, so clk_out never shows a runt pulse (except on rst).
//
// Ports
//   clk          source clock, all logic on posedge
//   rst          asynchronous active-high reset
//   en           run request for the divided clock
//   cfg_half     new half-period value, ratio = 2*(cfg_half+1)
//   cfg_vld      cfg_half valid, held by the source until accepted
//   cfg_rdy      block can accept a new cfg_half
//   clk_out      divided clock, registered
//   clk_active   high while the FSM is not in STOP
//   switch_done  one-cycle pulse after a pending cfg has been applied
module clk_div_switch #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  output logic             clk_out,
  output logic             clk_active,
  output logic             switch_done
);

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_q, pend_d;
  logic             cfg_rdy_q, cfg_rdy_d;
  logic             clk_out_q, clk_out_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             last_cnt;
  logic             apply_pt;
  logic             accept;

  assign last_cnt = (cnt_q == cur_half_q);
  // Apply points: any STOP cycle, or the last cycle of a high phase.
  assign apply_pt = (state_q == STOP) || ((state_q == RUN_HI) && last_cnt);
  assign accept   = cfg_vld && cfg_rdy_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STOP;
      cnt_q       <= '0;
      cur_half_q  <= CNT_W'(DEFAULT_HALF);
      pend_half_q <= '0;
      pend_q      <= 1'b0;
      cfg_rdy_q   <= 1'b1;
      clk_out_q   <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_half_q  <= cur_half_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      cfg_rdy_q   <= cfg_rdy_d;
      clk_out_q   <= clk_out_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP:   if (en) state_d = RUN_LO;
      RUN_LO: begin
        // Leaving from low can only lengthen the low level, never shorten it.
        if (!en)           state_d = STOP;
        else if (last_cnt) state_d = RUN_HI;
      end
      RUN_HI: begin
        // The high phase always completes; en is only looked at its end.
        if (last_cnt) state_d = en ? RUN_LO : STOP;
      end
      default: state_d = STOP;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    cur_half_d  = cur_half_q;
    pend_half_d = pend_half_q;
    pend_d      = pend_q;
    cfg_rdy_d   = cfg_rdy_q;
    done_d      = 1'b0;

    unique case (state_q)
      STOP:    cnt_d = '0;
      RUN_LO:  cnt_d = (!en || last_cnt) ? '0 : cnt_q + CNT_W'(1);
      RUN_HI:  cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase

    // pend_q is never set while cfg_rdy_q is high, so accept and apply
    // cannot collide; a config accepted on an apply point waits for the next.
    if (apply_pt && pend_q) begin
      cur_half_d = pend_half_q;
      pend_d     = 1'b0;
      cfg_rdy_d  = 1'b1;
      done_d     = 1'b1;
    end else if (accept) begin
      pend_half_d = cfg_half;
      pend_d      = 1'b1;
      cfg_rdy_d   = 1'b0;
    end

    // Outputs are registered images of the next state.
    clk_out_d = (state_d == RUN_HI);
    active_d  = (state_d != STOP);
  end

  assign cfg_rdy     = cfg_rdy_q;
  assign clk_out     = clk_out_q;
  assign clk_active  = active_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_clk_div_switch.sv
// tb_clk_div_switch
//   Lockstep bench: each cycle the driver sets inputs on negedge and pushes
//   the hand-derived expected outputs for the following posedge; a monitor
//   pops and compares them 1 time unit after that posedge.
module tb_clk_div_switch;

  typedef struct {
    logic co;
    logic act;
    logic rdy;
    logic dn;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] cfg_half;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic       clk_out;
  logic       clk_active;
  logic       switch_done;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc_no;
  exp_t        sb_q[$];

  clk_div_switch #(
    .CNT_W       (8),
    .DEFAULT_HALF(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_half   (cfg_half),
    .cfg_vld    (cfg_vld),
    .cfg_rdy    (cfg_rdy),
    .clk_out    (clk_out),
    .clk_active (clk_active),
    .switch_done(switch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (!rst && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("clk_out", {31'd0, clk_out}, {31'd0, e.co});
      chk("clk_active", {31'd0, clk_active}, {31'd0, e.act});
      chk("cfg_rdy", {31'd0, cfg_rdy}, {31'd0, e.rdy});
      chk("switch_done", {31'd0, switch_done}, {31'd0, e.dn});
    end
  end

  // One cycle: drive inputs for the next posedge and push what must follow it.
  task automatic cyc(input logic e, input logic v, input logic [7:0] h,
                     input logic co, input logic act, input logic rdy, input logic dn);
    exp_t x;
    en       = e;
    cfg_vld  = v;
    cfg_half = h;
    x.co  = co;
    x.act = act;
    x.rdy = rdy;
    x.dn  = dn;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n, input logic e, input logic co,
                     input logic act, input logic rdy);
    for (int unsigned i = 0; i < n; i++) cyc(e, 1'b0, 8'd0, co, act, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc_no   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    cfg_vld  = 1'b0;
    cfg_half = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_active", {31'd0, clk_active}, 32'd0);
    chk("rst_rdy", {31'd0, cfg_rdy}, 32'd1);
    chk("rst_done", {31'd0, switch_done}, 32'd0);
    rst = 1'b0;

    // 1: default /4, first rise after a full 2-cycle low
    for (int unsigned p = 0; p < 3; p++) begin
      run(2, 1'b1, 1'b0, 1'b1, 1'b1);
      run(2, 1'b1, 1'b1, 1'b1, 1'b1);
    end

    // 2: half=3 accepted in the first high cycle, applied at the falling edge
    run(2, 1'b1, 1'b0, 1'b1, 1'b1);
    run(1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    run(3, 1'b1, 1'b0, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1, 1'b1, 1'b1);
    run(4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1, 1'b1, 1'b1);

    // 3: en dropped in high phase, then in low phase, then re-enabled
    run(4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(1, 1'b1, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0, 1'b1);
    run(4, 1'b1, 1'b0, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1, 1'b1, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: half=0 applied in STOP, then /2 toggling
    cyc(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned p = 0; p < 4; p++) begin
      run(1, 1'b1, 1'b0, 1'b1, 1'b1);
      run(1, 1'b1, 1'b1, 1'b1, 1'b1);
    end

    // 5: back-to-back configs 2 then 5 with cfg_vld held
    cyc(1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(3, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    run(5, 1'b1, 1'b0, 1'b1, 1'b1);
    run(6, 1'b1, 1'b1, 1'b1, 1'b1);
    run(6, 1'b1, 1'b0, 1'b1, 1'b1);

    // 6: async reset mid-high with a pending config
    cyc(1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("arst_active", {31'd0, clk_active}, 32'd0);
    chk("arst_rdy", {31'd0, cfg_rdy}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned p = 0; p < 2; p++) begin
      run(2, 1'b1, 1'b0, 1'b1, 1'b1);
      run(2, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    run(1, 1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_switch.md
Name: clk_div_switch

Overview:
- Single-clock, glitch-free programmable clock divider.
- Derives a 50%-duty divided clock from clk with even ratio 2*(half+1). The ratio can be changed at runtime through a valid/ready handshake.
- New ratios and stop requests take effect only at phase boundaries, so no runt high or low pulses are produced.
- Used wherever the design must switch a derived clock between rates without glitching downstream logic.

Parameters:
- CNT_W, 8, width of the half-period configuration and of the internal counter.
- DEFAULT_HALF, 1, half-period value loaded at reset (divide-by-4).

Ports:
- clk  input  1  source clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request for the divided clock.
- cfg_half  input  CNT_W  new half-period value; ratio = 2*(cfg_half+1).
- cfg_vld  input  1  cfg_half valid.
- cfg_rdy  output  1  block can accept a new cfg_half.
- clk_out  output  1  divided clock, registered.
- clk_active  output  1  high when the FSM is not in STOP.
- switch_done  output  1  one-cycle pulse after a pending cfg is applied.

Behaviour:
- Reset and clock (already decided): one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=STOP, clk_out=0, cnt=0, cur_half=DEFAULT_HALF.
  - pend=0, cfg_rdy=1, switch_done=0, clk_active=0.
- All outputs are registered.
- FSM states: STOP, RUN_LO, RUN_HI.
  - STOP: clk_out=0, cnt held 0.
    - en=1 -> RUN_LO, cnt=0.
    - If pend=1: apply pend (cur_half<=pend_half) in the same cycle, pend cleared, switch_done pulse next cycle.
  - RUN_LO: clk_out=0.
    - en=0 -> STOP immediately (low phase may only be lengthened, never shortened).
    - Else if cnt==cur_half -> RUN_HI, clk_out<=1, cnt<=0.
    - Else cnt++.
  - RUN_HI: clk_out=1; the high phase always completes, regardless of en.
    - cnt==cur_half -> clk_out<=0, cnt<=0, apply pend if set; next state en ? RUN_LO : STOP.
    - Else cnt++.
- Phase lengths: each phase lasts exactly cur_half+1 clk cycles.
  - half=0 gives clk_out toggling every cycle (/2).
  - Max half=2^CNT_W-1.
- First rising edge after leaving STOP follows a full low phase.
- Config handshake:
  - Transfer when cfg_vld & cfg_rdy: pend_half<=cfg_half, pend<=1, cfg_rdy<=0 next cycle.
  - cfg_vld is held by the source until accepted; cfg_half is ignored while cfg_rdy=0.
  - Apply point is the RUN_HI->low transition (falling edge), or any cycle in STOP.
  - On apply: cur_half updated, pend cleared, cfg_rdy<=1 and switch_done<=1 in the following cycle (one cycle wide).
  - A config accepted in the same cycle as an apply point is not forwarded; it waits for the next apply point.
- Simultaneous events:
  - en falling in the RUN_HI last cycle: apply pend, then go to STOP.
  - en rising in STOP with pend: new ratio is used for the first low phase.
- Reset mid-operation: clk_out forced 0 asynchronously (a runt is permitted; downstream must share rst); pending config is discarded.
- clk_active is registered from the next state; it deasserts in the same cycle clk_out reaches its final low.

Test Plan:
1. Reset, en=1 held, default half=1 -> clk_out first rises 3 clk edges after en sampled; period 4, exactly 2 high / 2 low; clk_active=1; cfg_rdy=1.
2. Running half=1, cfg_half=3 accepted mid-high -> current high completes 2 cycles, then low 4 / high 4; cfg_rdy low from accept until cycle after apply; one switch_done pulse.
3. en dropped on the first high cycle (half=3) -> high lasts 4 cycles, clk_out 0 thereafter, clk_active 0; en dropped in low phase -> STOP next cycle, low held; re-enable gives full 4-cycle low then rise.
4. STOP, cfg_half=0 sent -> applied next cycle, switch_done pulse, cfg_rdy back to 1; en=1 -> /2 toggling, alternating 1-cycle phases.
5. Back-to-back configs 2 then 5 with cfg_vld held -> second accepted only after first applies; ratios 6 then 12 appear in order, two switch_done pulses, no phase shorter than min(old,new) half+1.
6. rst asserted mid-high with pend set -> clk_out 0 asynchronously; after release cur_half=1, pend=0, cfg_rdy=1, state STOP.
